// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: default widths, initiator port state type
// and a width helper for the per-transaction bit counter.
package bus_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    MP_IDLE,
    MP_REQ,
    MP_ADDR,
    MP_WDATA,
    MP_WAIT,
    MP_RDATA,
    MP_SPLIT,
    MP_DONE
  } mp_state_t;

  // Counter must hold the largest field length without wrapping.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/master_port_if.sv
// Initiator-side serial bus port signals: parallel request/response towards
// the initiator, request/grant towards the arbiter, serial lanes to the target.
interface master_port_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = bus_pkg::ADDR_W,
  parameter int DATA_W = bus_pkg::DATA_W
) ();

  logic              par_in_valid;
  logic              par_in_write;
  logic [ADDR_W-1:0] par_addr;
  logic [DATA_W-1:0] par_wdata;
  logic              par_out_ready;
  logic              par_out_valid;
  logic [DATA_W-1:0] par_rdata;
  logic              bus_req;
  logic              bus_grant;
  logic              ser_out_valid;
  logic              out_write;
  logic              ser_addr;
  logic              ser_wdata;
  logic              ser_in_valid;
  logic              ser_rdata;
  logic              in_split_en;

  // The port itself.
  modport master (
    input  par_in_valid, par_in_write, par_addr, par_wdata,
    input  bus_grant, ser_in_valid, ser_rdata, in_split_en,
    output par_out_ready, par_out_valid, par_rdata,
    output bus_req, ser_out_valid, out_write, ser_addr, ser_wdata
  );

  // Everything around the port: initiator, arbiter and target.
  modport slave (
    output par_in_valid, par_in_write, par_addr, par_wdata,
    output bus_grant, ser_in_valid, ser_rdata, in_split_en,
    input  par_out_ready, par_out_valid, par_rdata,
    input  bus_req, ser_out_valid, out_write, ser_addr, ser_wdata
  );

endinterface

// File: rtl/ser_shift_reg.sv
// Right-shifting serialiser/deserialiser: parallel load, then each enabled
// cycle bit 0 leaves and sin enters at the MSB. With sin tied low it emits a
// word LSB-first; fed with serial data it assembles an LSB-first word.
module ser_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         en,
  input  logic         sin,
  output logic [W-1:0] q
);

  // Load has priority so a new transaction always starts from fresh data.
  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= din;
    else if (en)   q <= {sin, q[W-1:1]};
  end

endmodule

// File: rtl/master_port.sv
// Initiator-side serial bus port. Accepts one parallel request, requests the
// bus, shifts address (and write data) out LSB-first while granted, then
// collects the write ack or the serial read byte, honouring target splits.
module master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W = bus_pkg::ADDR_W,
  parameter int DATA_W = bus_pkg::DATA_W
) (
  input logic           in_clk,
  input logic           reset,
  master_port_if.master mp
);

  localparam int CNT_W = cnt_width(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W - 1);

  mp_state_t         state, nxt, saved;
  logic [CNT_W-1:0]  cnt;
  logic              wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  logic accept, a_step, d_step, r_step;
  logic rdy, done_vld, req, sov, wr_out, saddr, swdata;
  logic [DATA_W-1:0] rdata;

  // A bit only moves when it is actually on the wire (granted) or, for
  // reads, when the target qualifies it outside a split.
  assign accept = (state == MP_IDLE) && mp.par_in_valid;
  assign a_step = (state == MP_ADDR) && mp.bus_grant;
  assign d_step = (state == MP_WDATA) && mp.bus_grant;
  assign r_step = (state == MP_RDATA) && mp.ser_in_valid && !mp.in_split_en;

  ser_shift_reg #(.W(ADDR_W)) u_addr_sr (
    .clk(in_clk), .reset(reset), .load(accept), .din(mp.par_addr),
    .en(a_step), .sin(1'b0), .q(addr_q)
  );

  ser_shift_reg #(.W(DATA_W)) u_wdata_sr (
    .clk(in_clk), .reset(reset), .load(accept), .din(mp.par_wdata),
    .en(d_step), .sin(1'b0), .q(wdata_q)
  );

  ser_shift_reg #(.W(DATA_W)) u_rdata_sr (
    .clk(in_clk), .reset(reset), .load(accept), .din('0),
    .en(r_step), .sin(mp.ser_rdata), .q(rdata_q)
  );

  // Only bit 0 of the outgoing registers is ever driven onto the bus.
  logic unused_sr_bits;
  assign unused_sr_bits = ^{addr_q[ADDR_W-1:1], wdata_q[DATA_W-1:1]};

  // State register.
  always_ff @(posedge in_clk) begin
    if (reset) state <= MP_IDLE;
    else       state <= nxt;
  end

  // Bit counter, latched direction and the state to resume after a split.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      cnt   <= '0;
      wr    <= 1'b0;
      saved <= MP_IDLE;
    end else begin
      if (accept) begin
        cnt <= '0;
        wr  <= mp.par_in_write;
      end else if (a_step) begin
        cnt <= (cnt == A_LAST) ? '0 : cnt + CNT_W'(1);
      end else if (d_step) begin
        cnt <= (cnt == D_LAST) ? '0 : cnt + CNT_W'(1);
      end else if (r_step) begin
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == MP_WAIT || state == MP_RDATA) && mp.in_split_en)
        saved <= state;
    end
  end

  // Next-state logic; split wins over a coincident ser_in_valid.
  always_comb begin
    nxt = state;
    case (state)
      MP_IDLE:  if (mp.par_in_valid) nxt = MP_REQ;
      MP_REQ:   if (mp.bus_grant) nxt = MP_ADDR;
      MP_ADDR:  if (mp.bus_grant && cnt == A_LAST) nxt = wr ? MP_WDATA : MP_RDATA;
      MP_WDATA: if (mp.bus_grant && cnt == D_LAST) nxt = MP_WAIT;
      MP_WAIT: begin
        if (mp.in_split_en)       nxt = MP_SPLIT;
        else if (mp.ser_in_valid) nxt = MP_DONE;
      end
      MP_RDATA: begin
        if (mp.in_split_en)                          nxt = MP_SPLIT;
        else if (mp.ser_in_valid && cnt == D_LAST)   nxt = MP_DONE;
      end
      MP_SPLIT: if (!mp.in_split_en && mp.bus_grant) nxt = saved;
      MP_DONE:  nxt = MP_IDLE;
      default:  nxt = MP_IDLE;
    endcase
  end

  // Outputs decoded from state; bit-valid follows grant in the same cycle.
  always_comb begin
    rdy      = 1'b0;
    done_vld = 1'b0;
    rdata    = '0;
    req      = 1'b0;
    sov      = 1'b0;
    saddr    = 1'b0;
    swdata   = 1'b0;
    wr_out   = (state != MP_IDLE) && wr;
    case (state)
      MP_IDLE: rdy = 1'b1;
      MP_REQ:  req = 1'b1;
      MP_ADDR: begin
        req   = 1'b1;
        sov   = mp.bus_grant;
        saddr = addr_q[0];
      end
      MP_WDATA: begin
        req    = 1'b1;
        sov    = mp.bus_grant;
        swdata = wdata_q[0];
      end
      MP_WAIT, MP_RDATA: req = 1'b1;
      MP_SPLIT: req = !mp.in_split_en;
      MP_DONE: begin
        done_vld = 1'b1;
        rdata    = wr ? '0 : rdata_q;
      end
      default: ;
    endcase
  end

  assign mp.par_out_ready = rdy;
  assign mp.par_out_valid = done_vld;
  assign mp.par_rdata     = rdata;
  assign mp.bus_req       = req;
  assign mp.ser_out_valid = sov;
  assign mp.out_write     = wr_out;
  assign mp.ser_addr      = saddr;
  assign mp.ser_wdata     = swdata;

endmodule

// File: tb/tb_master_port.sv
// Randomised bench for master_port: acts as initiator, arbiter and target,
// and judges the port by the bit streams and completion it produces.
module tb_master_port;
  import bus_pkg::*;

  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   sprob  = 0;

  master_port_if #(.ADDR_W(AW), .DATA_W(DW)) mp ();

  master_port #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .in_clk(clk),
    .reset (rst),
    .mp    (mp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_quiet();
    mp.par_in_valid = 1'b0;
    mp.par_in_write = 1'b0;
    mp.par_addr     = '0;
    mp.par_wdata    = '0;
    mp.bus_grant    = 1'b0;
    mp.ser_in_valid = 1'b0;
    mp.ser_rdata    = 1'b0;
    mp.in_split_en  = 1'b0;
  endtask

  // One transaction. Inputs for cycle t are driven at its falling edge, the
  // outputs of cycle t are judged 1 time unit later. Cycle 0 is the accept.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rbyte, input int gprob, input int vprob,
                         input bit alt, input bit hold, input int drop_at, input int split_at,
                         input int split_len, input int rst_at, output int done_cyc);
    int na, nd, nr, t, pulses, last_ev, drops, spl_left;
    int bad_sov, bad_req, bad_ow, bad_rdy;
    bit got_grant, in_split, split_done, vtog, g, se, v, fin;
    logic [AW-1:0] abits;
    logic [DW-1:0] wbits;
    na = 0; nd = 0; nr = 0; pulses = 0; last_ev = -1; drops = 0; spl_left = 0;
    bad_sov = 0; bad_req = 0; bad_ow = 0; bad_rdy = 0;
    got_grant = 0; in_split = 0; split_done = 0; vtog = 0; fin = 0;
    abits = '0; wbits = '0; done_cyc = -1;

    @(negedge clk);
    #1;
    chk("idle_ready", mp.par_out_ready, 1);
    mp.par_in_valid = 1'b1;
    mp.par_in_write = wr;
    mp.par_addr     = addr;
    mp.par_wdata    = wdata;
    mp.bus_grant    = 1'b0;
    mp.ser_in_valid = 1'b0;
    mp.in_split_en  = 1'b0;
    t = 0;

    while (!fin) begin
      @(negedge clk);
      t++;
      if (t > 400) begin
        chk("timeout_cycles", t, 400);
        drive_quiet();
        return;
      end
      if (!hold || (last_ev >= 0 && t == last_ev + 1)) mp.par_in_valid = 1'b0;

      // choose this cycle's arbiter/target behaviour
      if (na < AW || (wr && nd < DW)) begin
        se = 0; v = 0;
        if (drop_at >= 0 && na == drop_at && drops < 3) begin
          g = 0; drops++;
        end else g = (int'($urandom_range(99)) < gprob);
      end else if (last_ev >= 0) begin
        g = 0; se = 0; v = 0;
      end else if (in_split) begin
        if (spl_left > 0) begin se = 1; spl_left--; end
        else se = 0;
        g = (int'($urandom_range(99)) < gprob);
        v = 1'($urandom_range(1));
      end else begin
        vtog = ~vtog;
        if (!wr && split_at >= 0 && nr == split_at && !split_done) begin
          split_done = 1; se = 1; spl_left = split_len - 1; v = 1;
        end else if (split_at < 0 && int'($urandom_range(99)) < sprob) begin
          se = 1; spl_left = int'($urandom_range(3)); v = 1'($urandom_range(1));
        end else begin
          se = 0;
          v  = alt ? vtog : (int'($urandom_range(99)) < vprob);
        end
        g = (int'($urandom_range(99)) < gprob);
      end
      mp.bus_grant    = g;
      mp.in_split_en  = se;
      mp.ser_in_valid = v;
      // bits offered while split carry the wrong value so accepting one shows
      if (se || in_split) mp.ser_rdata = ~rbyte[nr];
      else if (v)         mp.ser_rdata = rbyte[nr];
      else                mp.ser_rdata = 1'($urandom_range(1));

      #1;
      if (mp.par_out_valid) pulses++;

      if (last_ev >= 0 && t == last_ev + 1) begin
        chk("done_valid", mp.par_out_valid, 1);
        chk("done_rdata", mp.par_rdata, wr ? 8'h00 : rbyte);
        chk("done_bus_req", mp.bus_req, 0);
        chk("done_out_write", mp.out_write, wr);
        done_cyc = t;
      end else if (last_ev >= 0 && t == last_ev + 2) begin
        chk("ready_after_done", mp.par_out_ready, 1);
        chk("pulse_count", pulses, 1);
        fin = 1;
      end else begin
        if (mp.par_out_ready) bad_rdy++;
        if (mp.out_write !== wr) bad_ow++;
        if (na < AW || (wr && nd < DW)) begin
          if (mp.ser_out_valid !== (got_grant & g)) bad_sov++;
          if (mp.bus_req !== 1'b1) bad_req++;
          if (got_grant && g) begin
            if (na < AW) begin abits[na] = mp.ser_addr; na++; end
            else begin wbits[nd] = mp.ser_wdata; nd++; end
          end
          if (g) got_grant = 1;
        end else begin
          if (mp.ser_out_valid !== 1'b0) bad_sov++;
          if (in_split) begin
            if (mp.bus_req !== !se) bad_req++;
            if (!se && g) in_split = 0;
          end else begin
            if (mp.bus_req !== 1'b1) bad_req++;
            if (se) in_split = 1;
            else if (v) begin
              if (wr) last_ev = t;
              else begin
                nr++;
                if (nr == DW) last_ev = t;
              end
            end
          end
        end

        if (rst_at > 0 && wr && nd == rst_at && na == AW) begin
          rst = 1'b1;
          drive_quiet();
          @(negedge clk);
          rst = 1'b0;
          #1;
          chk("midrst_ready", mp.par_out_ready, 1);
          chk("midrst_bus_req", mp.bus_req, 0);
          chk("midrst_ser_valid", mp.ser_out_valid, 0);
          chk("midrst_out_write", mp.out_write, 0);
          chk("midrst_out_valid", mp.par_out_valid, 0);
          return;
        end
      end
    end

    drive_quiet();
    chk("addr_stream", abits, addr);
    if (wr) chk("wdata_stream", wbits, wdata);
    chk("ser_valid_errs", bad_sov, 0);
    chk("bus_req_errs", bad_req, 0);
    chk("out_write_errs", bad_ow, 0);
    chk("busy_ready_errs", bad_rdy, 0);
  endtask

  initial begin
    int dc;
    bit rw;
    rst = 1'b1;
    drive_quiet();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", mp.par_out_ready, 1);
    chk("rst_bus_req", mp.bus_req, 0);
    chk("rst_ser_valid", mp.ser_out_valid, 0);
    chk("rst_out_write", mp.out_write, 0);
    chk("rst_out_valid", mp.par_out_valid, 0);
    chk("rst_rdata", mp.par_rdata, 0);
    rst = 1'b0;

    // write, grant held, immediate ack
    run_txn(1, 12'hA5C, 8'h3C, 8'h00, 100, 100, 0, 0, -1, -1, 0, -1, dc);
    chk("wr_done_cycle", dc, 23);
    // read with target gaps every other cycle
    run_txn(0, 12'h123, 8'h00, 8'h96, 100, 0, 1, 0, -1, -1, 0, -1, dc);
    // read, grant held, contiguous bits from the first RDATA cycle
    run_txn(0, 12'h3F0, 8'h00, 8'h5A, 100, 100, 0, 0, -1, -1, 0, -1, dc);
    chk("rd_done_cycle", dc, 22);
    // grant dropped for 3 cycles after the 5th address bit
    run_txn(1, 12'h7E1, 8'hC3, 8'h00, 100, 100, 0, 0, 5, -1, 0, -1, dc);
    chk("drop_done_cycle", dc, 26);
    // split after 3 read bits for 10 cycles, coincident bit offered
    run_txn(0, 12'h0B4, 8'h00, 8'hE7, 100, 100, 0, 0, -1, 3, 10, -1, dc);
    chk("split_done_cycle", dc, 22 + 10 + 1);
    // reset in the middle of write data, then a normal write
    run_txn(1, 12'h555, 8'hAA, 8'h00, 100, 100, 0, 0, -1, -1, 0, 3, dc);
    run_txn(1, 12'h2C9, 8'h81, 8'h00, 100, 100, 0, 0, -1, -1, 0, -1, dc);
    chk("post_rst_done_cycle", dc, 23);
    // par_in_valid held high across whole transactions
    run_txn(1, 12'hFFF, 8'hFF, 8'h00, 100, 100, 0, 1, -1, -1, 0, -1, dc);
    run_txn(0, 12'h001, 8'h00, 8'h01, 80, 70, 0, 1, -1, -1, 0, -1, dc);

    // randomised traffic with grant gaps, target gaps and splits
    sprob = 15;
    for (int i = 0; i < 30; i++) begin
      rw = 1'($urandom_range(1));
      run_txn(rw, AW'($urandom), DW'($urandom), DW'($urandom),
              int'($urandom_range(100, 50)), int'($urandom_range(100, 30)),
              1'b0, 1'($urandom_range(1)), -1, -1, 0, -1, dc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/master_port.md
# master_port

Initiator-side serial bus port: accepts one parallel read or write request per transaction from an initiator (master) and requests the interconnect. Once granted, it serialises the address and write data LSB-first and collects the serial read data or write acknowledge from the target. It is the counterpart of the target-side serial port, sitting between each initiator and the bus interconnect/arbiter.

## Interface
- ADDR_W, 12, address width (serialised bits)
- DATA_W, 8, data width (serialised bits)
- in_clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- par_in_valid  in  1  initiator request valid
- par_in_write  in  1  1 = write, 0 = read (sampled at accept)
- par_addr  in  ADDR_W  request address (sampled at accept)
- par_wdata  in  DATA_W  write data (sampled at accept)
- par_out_ready  out  1  port idle, can accept a request
- par_out_valid  out  1  one-cycle completion pulse
- par_rdata  out  DATA_W  read data, valid with par_out_valid (0 for writes)
- bus_req  out  1  bus request to arbiter
- bus_grant  in  1  bus grant from arbiter
- ser_out_valid  out  1  qualifies ser_addr/ser_wdata bit this cycle
- out_write  out  1  transaction direction, held for whole transaction
- ser_addr  out  1  serial address bit
- ser_wdata  out  1  serial write data bit
- ser_in_valid  in  1  read: qualifies ser_rdata bit; write: one-cycle ack
- ser_rdata  in  1  serial read data bit
- in_split_en  in  1  target split: release bus, wait

## Operation
- States: IDLE, REQ, ADDR, WDATA, WAIT, RDATA, SPLIT, DONE. Moore outputs.
- IDLE: par_out_ready=1. par_in_valid=1 -> latch addr/wdata/write into shift regs, clear counter, -> REQ.
- REQ: bus_req=1; bus_grant=1 -> ADDR.
- ADDR: bus_req=1; ser_out_valid=bus_grant; ser_addr=addr_sr[0]. On each granted cycle shift and increment count; after ADDR_W granted bits -> WDATA if write else RDATA. bus_grant=0 pauses (count and shift reg held).
- WDATA: same as ADDR for DATA_W bits on ser_wdata -> WAIT.
- WAIT (write): ser_in_valid=1 -> DONE.
- RDATA: each cycle with ser_in_valid=1 shifts ser_rdata in at MSB (LSB-first) and increments count; gaps allowed; DATA_W bits -> DONE.
- SPLIT: entered from WAIT/RDATA when in_split_en=1 (priority over ser_in_valid same cycle; that bit is ignored). bus_req=0. When in_split_en=0 and bus_grant=1, return to saved state; bus_req=1 once in_split_en=0. Count preserved.
- DONE: par_out_valid=1, par_rdata=received byte (read) or 0 (write); bus_req=0; -> IDLE.
- out_write = latched write bit in all non-IDLE states, 0 in IDLE.
- Counter width $clog2(max(ADDR_W,DATA_W)+1); no wrap within transaction.
- par_in_valid outside IDLE ignored; no queuing.

## Timing
- Reset (any state, mid-transaction included): next cycle state=IDLE, counter/shift regs 0; par_out_ready=1, all other outputs 0.
- Write, grant held from REQ, ack immediate: accept cycle 0; REQ cycle 1; address bits cycles 2..13; data bits 14..21; WAIT 22; ack in 22 -> par_out_valid cycle 23; par_out_ready again cycle 24.
- Read, grant held, target returns 8 contiguous bits starting cycle 15: address 2..13, RDATA from 14, last bit cycle 22, par_out_valid cycle 23.
- bus_grant sampled same cycle as bit driven: a bit counts only if ser_out_valid=1.
- Accept and DONE never overlap; minimum spacing between accepts is 24 cycles (write) with defaults.

## Structure
- Shared package bus_pkg: ADDR_W/DATA_W defaults, master_port state enum type, shared with the target-side port.
- One sub-module ser_shift_reg (parameterised width, load/shift-out LSB and shift-in-at-MSB modes, enable), instantiated for address, write data and read data.

## Test plan
- Write addr 0xA5C, data 0x3C, grant held, ack at cycle 22 -> ser_addr bits 0,0,1,1,1,0,1,0,0,1,0,1 cycles 2..13; ser_wdata 0,0,1,1,1,1,0,0 cycles 14..21; par_out_valid cycle 23.
- Read addr 0x123, target returns 0x96 LSB-first with ser_in_valid gaps every other cycle -> par_rdata=0x96 with par_out_valid one cycle after 8th bit.
- Grant dropped for 3 cycles after 5th address bit -> ser_out_valid=0 for those 3 cycles, bits 6..12 resume unchanged, total 12 valid bits.
- Read with in_split_en asserted after 3 data bits for 10 cycles (plus coincident ser_in_valid) -> bus_req low during split, coincident bit ignored, remaining 5 bits after regrant assemble correct byte.
- Reset asserted mid-WDATA -> next cycle par_out_ready=1, bus_req/ser_out_valid/out_write=0; following request completes normally.
- par_in_valid held high through a transaction -> exactly one request accepted per IDLE visit.
